snowflake_mtimer: RTL and testbench

//   Memory-mapped RISC-V machine timer (mtime/mtimecmp) acting as a responder on the core data
//   bus req/ack protocol. Sits behind the system bus address decode next to the GPIO/7-seg

---
 rtl/snowflake_mtimer.sv | 167 ++++++++++++++++
 tb/tb_snowflake_mtimer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snowflake_mtimer.sv
// Memory-mapped RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a level
// interrupt. It answers the core data bus req/ack handshake with a fixed one-cycle latency.
module snowflake_mtimer #(
  parameter int unsigned PRESCALE = 24  // clk cycles per mtime increment, 1..65535
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  input  logic [3:0]  bus_mask,
  input  logic        bus_wr_en,
  input  logic        bus_req,
  output logic [31:0] bus_rd_data,
  output logic        bus_ack,
  output logic        timer_interrupt
);

  // Register offsets, decoded from bus_addr[4:2].
  localparam logic [2:0] OffMtimeLo = 3'd0;
  localparam logic [2:0] OffMtimeHi = 3'd1;
  localparam logic [2:0] OffCmpLo   = 3'd2;
  localparam logic [2:0] OffCmpHi   = 3'd3;
  localparam logic [2:0] OffCtrl    = 3'd4;

  localparam logic [15:0] PsLast = 16'(PRESCALE - 1);

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ps_q, ps_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rd_q, rd_d;
  logic        irq_q, irq_d;

  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic [2:0]  offset;
  logic        tick;
  logic [63:0] mtime_inc;

  // Only the word offset inside the block is decoded.
  logic unused_addr;
  assign unused_addr = ^{bus_addr[31:5], bus_addr[1:0]};

  assign offset = bus_addr[4:2];
  assign access = (state_q == StIdle) && bus_req;
  assign wr_acc = access && bus_wr_en;
  assign rd_acc = access && !bus_wr_en;

  assign bus_ack         = (state_q == StAck);
  assign bus_rd_data     = rd_q;
  assign timer_interrupt = irq_q;

  // Byte-lane merge: lanes with their mask bit set take the new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = mask[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Handshake FSM next state: every sampled request gets exactly one ack cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_req) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Prescaler: wraps on terminal count and holds its phase while counting is disabled.
  always_comb begin
    tick = en_q && (ps_q == PsLast);
    ps_d = ps_q;
    if (en_q) begin
      ps_d = tick ? 16'd0 : ps_q + 16'd1;
    end
  end

  // Register file update. Unwritten mtime bytes take the incremented value, so a write in a
  // tick cycle does not lose that tick.
  always_comb begin
    mtime_inc = mtime_q + {63'd0, tick};
    mtime_d   = mtime_inc;
    cmp_d     = cmp_q;
    en_d      = en_q;
    ie_d      = ie_q;
    if (wr_acc) begin
      case (offset)
        OffMtimeLo: mtime_d[31:0]  = merge_bytes(mtime_inc[31:0], bus_wr_data, bus_mask);
        OffMtimeHi: mtime_d[63:32] = merge_bytes(mtime_inc[63:32], bus_wr_data, bus_mask);
        OffCmpLo:   cmp_d[31:0]    = merge_bytes(cmp_q[31:0], bus_wr_data, bus_mask);
        OffCmpHi:   cmp_d[63:32]   = merge_bytes(cmp_q[63:32], bus_wr_data, bus_mask);
        OffCtrl: begin
          if (bus_mask[0]) begin
            en_d = bus_wr_data[0];
            ie_d = bus_wr_data[1];
          end
        end
        default: ;
      endcase
    end
  end

  // Read path. A MTIME_LO read snapshots the upper half so a following MTIME_HI read
  // returns a coherent 64-bit value even if a carry happens in between.
  always_comb begin
    rd_d     = rd_q;
    shadow_d = shadow_q;
    if (rd_acc) begin
      case (offset)
        OffMtimeLo: begin
          rd_d     = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        OffMtimeHi: rd_d = shadow_q;
        OffCmpLo:   rd_d = cmp_q[31:0];
        OffCmpHi:   rd_d = cmp_q[63:32];
        OffCtrl:    rd_d = {30'd0, ie_q, en_q};
        default:    rd_d = 32'd0;
      endcase
    end
  end

  // Interrupt level follows the current registers with one cycle of lag.
  always_comb begin
    irq_d = ie_q && (mtime_q >= cmp_q);
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      ps_q     <= 16'd0;
      mtime_q  <= 64'd0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      shadow_q <= 32'd0;
      rd_q     <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      shadow_q <= shadow_d;
      rd_q     <= rd_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_snowflake_mtimer.sv
// Bench for snowflake_mtimer: one instance with PRESCALE=4 and one with PRESCALE=1 sharing the
// bus data lines; each has its own request. Reads go through an expected-value queue.
module tb_snowflake_mtimer;

  logic        clk = 1'b0;
  logic        RSTN;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [3:0]  bus_mask;
  logic        bus_wr_en;
  logic        req4, req1;
  logic [31:0] rd4, rd1;
  logic        ack4, ack1;
  logic        irq4, irq1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  snowflake_mtimer #(.PRESCALE(4)) u_dut4 (
    .clk             (clk),
    .RSTN            (RSTN),
    .bus_addr        (bus_addr),
    .bus_wr_data     (bus_wr_data),
    .bus_mask        (bus_mask),
    .bus_wr_en       (bus_wr_en),
    .bus_req         (req4),
    .bus_rd_data     (rd4),
    .bus_ack         (ack4),
    .timer_interrupt (irq4)
  );

  snowflake_mtimer #(.PRESCALE(1)) u_dut1 (
    .clk             (clk),
    .RSTN            (RSTN),
    .bus_addr        (bus_addr),
    .bus_wr_data     (bus_wr_data),
    .bus_mask        (bus_mask),
    .bus_wr_en       (bus_wr_en),
    .bus_req         (req1),
    .bus_rd_data     (rd1),
    .bus_ack         (ack1),
    .timer_interrupt (irq1)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // One bus transfer; starts in a fresh cycle so the responder is idle, expects ack after one.
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask,
                      output logic [31:0] rdata);
    int n;
    bit got;
    @(posedge clk);
    #1;
    bus_addr    = addr;
    bus_wr_data = data;
    bus_mask    = mask;
    bus_wr_en   = wr;
    if (sel) req1 = 1'b1;
    else     req4 = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (sel ? ack1 : ack4) got = 1'b1;
    end
    req1  = 1'b0;
    req4  = 1'b0;
    rdata = sel ? rd1 : rd4;
    chk("ack_latency", 64'(n), 64'd1);
  endtask

  task automatic wr(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] mask);
    logic [31:0] r;
    xfer(sel, 1'b1, addr, data, mask, r);
  endtask

  task automatic rd_exp(input bit sel, input logic [31:0] addr, input logic [31:0] exp,
                        input string name);
    logic [31:0] r;
    logic [31:0] e;
    string       nm;
    exp_q.push_back(exp);
    nm_q.push_back(name);
    xfer(sel, 1'b0, addr, 32'd0, 4'h0, r);
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    chk(nm, {32'd0, r}, {32'd0, e});
  endtask

  task automatic add_vec(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [31:0] e, input string n);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.mask = m; v.exp = e; v.name = n;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] lo;
    int          n;
    bit          seen;

    bus_addr = 32'd0; bus_wr_data = 32'd0; bus_mask = 4'h0; bus_wr_en = 1'b0;
    req4 = 1'b1; req1 = 1'b1;
    RSTN = 1'b0;

    // Reset held with requests pending: nothing may respond.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_quiet", {60'd0, ack4, ack1, irq4, irq1}, 64'd0);
      chk("reset_rd_data", {rd4, rd1}, 64'd0);
    end
    req4 = 1'b0; req1 = 1'b0;
    #2 RSTN = 1'b1;

    // Register access vectors on the PRESCALE=4 instance, counting disabled.
    add_vec(1, 32'h08, 32'h1234_5678, 4'hF, 32'h0, "");
    add_vec(0, 32'h08, 32'h0,         4'h0, 32'h1234_5678, "cmp_lo_full");
    add_vec(1, 32'h08, 32'h0000_AB00, 4'h2, 32'h0, "");
    add_vec(0, 32'h08, 32'h0,         4'h0, 32'h1234_AB78, "cmp_lo_byte1");
    add_vec(0, 32'h0C, 32'h0,         4'h0, 32'hFFFF_FFFF, "cmp_hi_reset");
    add_vec(1, 32'h0C, 32'hA5A5_A5A5, 4'h9, 32'h0, "");
    add_vec(0, 32'h0C, 32'h0,         4'h0, 32'hA5FF_FFA5, "cmp_hi_mask9");
    add_vec(0, 32'h10, 32'h0,         4'h0, 32'h0,         "ctrl_reset");
    add_vec(1, 32'h10, 32'hFFFF_FFFE, 4'hF, 32'h0, "");
    add_vec(0, 32'h10, 32'h0,         4'h0, 32'h2,         "ctrl_ie_only");
    add_vec(1, 32'h10, 32'h0,         4'hF, 32'h0, "");
    add_vec(0, 32'h10, 32'h0,         4'h0, 32'h0,         "ctrl_cleared");
    add_vec(1, 32'h00, 32'h5,         4'hF, 32'h0, "");
    add_vec(1, 32'h04, 32'h7,         4'hF, 32'h0, "");
    add_vec(0, 32'h00, 32'h0,         4'h0, 32'h5,         "mtime_lo_wr");
    add_vec(0, 32'h04, 32'h0,         4'h0, 32'h7,         "mtime_hi_shadow");
    add_vec(1, 32'h04, 32'h9,         4'hF, 32'h0, "");
    add_vec(0, 32'h04, 32'h0,         4'h0, 32'h7,         "shadow_held");
    add_vec(0, 32'h00, 32'h0,         4'h0, 32'h5,         "mtime_lo_again");
    add_vec(0, 32'h04, 32'h0,         4'h0, 32'h9,         "shadow_updated");
    add_vec(1, 32'h18, 32'hDEAD_BEEF, 4'hF, 32'h0, "");
    add_vec(0, 32'h18, 32'h0,         4'h0, 32'h0,         "unmapped_18");
    add_vec(0, 32'h1C, 32'h0,         4'h0, 32'h0,         "unmapped_1c");
    add_vec(1, 32'h00, 32'hFFFF_FFFF, 4'h0, 32'h0, "");
    add_vec(0, 32'h00, 32'h0,         4'h0, 32'h5,         "mask0_noop");

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].wr) wr(1'b0, vq[i].addr, vq[i].data, vq[i].mask);
      else          rd_exp(1'b0, vq[i].addr, vq[i].exp, vq[i].name);
    end
    chk("irq4_idle", {63'd0, irq4}, 64'd0);

    // Counting with PRESCALE=4: 100 ticks in 400 clocks.
    wr(1'b0, 32'h00, 32'h0, 4'hF);
    wr(1'b0, 32'h04, 32'h0, 4'hF);
    wr(1'b0, 32'h10, 32'h1, 4'hF);
    repeat (400) @(posedge clk);
    xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, lo);
    chk("count_400", {63'd0, (lo >= 32'd99 && lo <= 32'd101)}, 64'd1);
    wr(1'b0, 32'h10, 32'h0, 4'hF);

    // Write in a tick cycle (PRESCALE=1): byte0 written, upper bytes carry from the increment;
    // the tick in the cycle that clears EN still lands.
    wr(1'b1, 32'h00, 32'h1234_56FE, 4'hF);
    wr(1'b1, 32'h10, 32'h1, 4'hF);
    wr(1'b1, 32'h00, 32'h0000_00AB, 4'h1);
    wr(1'b1, 32'h10, 32'h0, 4'hF);
    rd_exp(1'b1, 32'h00, 32'h1234_57AD, "tick_write_lo");
    rd_exp(1'b1, 32'h04, 32'h0, "tick_write_hi");

    // Carry and coherent LO/HI pairs across the 32-bit wrap.
    wr(1'b1, 32'h00, 32'hFFFF_FFF0, 4'hF);
    wr(1'b1, 32'h04, 32'h0, 4'hF);
    wr(1'b1, 32'h10, 32'h1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'h0, lo);
      rd_exp(1'b1, 32'h04, (lo >= 32'hF000_0000) ? 32'h0 : 32'h1, "coherent_hi");
    end
    xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'h0, lo);
    rd_exp(1'b1, 32'h04, 32'h1, "carry_hi");

    // Interrupt timing.
    wr(1'b1, 32'h10, 32'h0, 4'hF);
    wr(1'b1, 32'h00, 32'h0, 4'hF);
    wr(1'b1, 32'h04, 32'h0, 4'hF);
    wr(1'b1, 32'h08, 32'd10, 4'hF);
    wr(1'b1, 32'h0C, 32'h0, 4'hF);
    wr(1'b1, 32'h10, 32'h3, 4'hF);
    chk("irq_low_at_start", {63'd0, irq1}, 64'd0);
    n = 0;
    while (!irq1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    // mtime reaches 10 ten edges after the CTRL write; the level follows one edge later.
    chk("irq_rise_cycle", 64'(n), 64'd11);
    wr(1'b1, 32'h08, 32'd1000, 4'hF);
    chk("irq_lag_after_cmp", {63'd0, irq1}, 64'd1);
    @(posedge clk);
    #1;
    chk("irq_fall_after_cmp", {63'd0, irq1}, 64'd0);
    wr(1'b1, 32'h10, 32'h1, 4'hF);
    wr(1'b1, 32'h08, 32'h0, 4'hF);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (irq1) seen = 1'b1;
    end
    chk("irq_ie0_never", {63'd0, seen}, 64'd0);
    wr(1'b1, 32'h10, 32'h3, 4'hF);
    chk("irq_lag_after_ie", {63'd0, irq1}, 64'd0);
    @(posedge clk);
    #1;
    chk("irq_rise_after_ie", {63'd0, irq1}, 64'd1);
    wr(1'b1, 32'h10, 32'h1, 4'hF);
    @(posedge clk);
    #1;
    chk("irq_fall_after_ie_clr", {63'd0, irq1}, 64'd0);

    // Reset pulse while ack is high: ack drops at once, state returns to reset values.
    @(posedge clk);
    #1;
    bus_addr = 32'h08; bus_wr_en = 1'b0; bus_mask = 4'h0;
    req4 = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_before_reset", {63'd0, ack4}, 64'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("ack_dropped_by_reset", {63'd0, ack4}, 64'd0);
    chk("rd_cleared_by_reset", {32'd0, rd4}, 64'd0);
    @(posedge clk);
    #1;
    chk("ack_held_low_in_reset", {63'd0, ack4}, 64'd0);
    req4 = 1'b0;
    RSTN = 1'b1;
    rd_exp(1'b0, 32'h08, 32'hFFFF_FFFF, "cmp_lo_after_reset");
    rd_exp(1'b0, 32'h10, 32'h0, "ctrl_after_reset");
    rd_exp(1'b1, 32'h00, 32'h0, "mtime_after_reset");
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
